// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - shared iterative binary-to-BCD converter with two-way round-robin arbitration
//
// Purpose:
//   One shift-add-3 datapath converts a binary operand to packed BCD, one bit per
//   clock. Two requesters share it. A round-robin arbiter picks the winner when
//   both ask at once.
//
// Ports:
//   clk      in   1          rising-edge clock
//   rstn     in   1          asynchronous active-low reset
//   req0     in   1          requester 0 request level, held until ack0
//   data0    in   IN_W       requester 0 operand, sampled at its grant edge only
//   req1     in   1          requester 1 request level, held until ack1
//   data1    in   IN_W       requester 1 operand, sampled at its grant edge only
//   ack0     out  1          one-cycle pulse, requester 0 result on bcd_out
//   ack1     out  1          one-cycle pulse, requester 1 result on bcd_out
//   busy     out  1          conversion granted or in progress
//   done     out  1          one-cycle pulse, ack0 | ack1
//   done_id  out  1          owner of the current/last result
//   bcd_out  out  4*DIGITS   packed BCD, digit 0 in [3:0], held until next done
//   ovf      out  1          operand needed more than DIGITS digits, held with bcd_out
module bcd_conv_sched #(
  parameter int IN_W   = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0,
  input  logic [IN_W-1:0]       data0,
  input  logic                  req1,
  input  logic [IN_W-1:0]       data1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  busy,
  output logic                  done,
  output logic                  done_id,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = IN_W + BW;
  localparam int CW = $clog2(IN_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [SW-1:0]   r_shreg;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf_acc;
  logic            r_owner;
  logic            r_last_served;
  logic [BW-1:0]   r_bcd_out;
  logic            r_ovf;
  logic            r_done_id;

  logic            w_any_req;
  logic            w_grant_id;
  logic [IN_W-1:0] w_grant_data;
  logic            w_last_shift;
  logic [SW-1:0]   w_adj;
  logic [SW-1:0]   w_shifted;
  logic            w_ovf_next;

  // When both requesters ask, the one not served last wins. last_served
  // resets to 1, so the first contest after reset goes to requester 0.
  assign w_any_req    = req0 | req1;
  assign w_grant_id   = (req0 && req1) ? ~r_last_served : req1;
  assign w_grant_data = w_grant_id ? data1 : data0;
  assign w_last_shift = (r_cnt == CW'(IN_W - 1));

  // Each BCD digit field is adjusted on its own. A digit <= 9 plus 3 stays
  // below 16, so no carry crosses into the next digit. The shift then moves
  // the digit's MSB up into the digit above.
  always_comb begin
    w_adj = r_shreg;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_shreg[IN_W + 4*d +: 4] > 4'd4) begin
        w_adj[IN_W + 4*d +: 4] = r_shreg[IN_W + 4*d +: 4] + 4'd3;
      end
    end
  end

  assign w_shifted  = {w_adj[SW-2:0], 1'b0};
  assign w_ovf_next = r_ovf_acc | w_adj[SW-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_next_state = S_CONV;
        end
      end
      S_CONV: begin
        busy = 1'b1;
        if (w_last_shift) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        ack0         = ~r_owner;
        ack1         = r_owner;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign done_id = r_done_id;
  assign bcd_out = r_bcd_out;
  assign ovf     = r_ovf;

  // The result registers are loaded on the final shift edge, so they already
  // show the new result during the DONE cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shreg       <= '0;
      r_cnt         <= '0;
      r_ovf_acc     <= 1'b0;
      r_owner       <= 1'b0;
      r_last_served <= 1'b1;
      r_bcd_out     <= '0;
      r_ovf         <= 1'b0;
      r_done_id     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_shreg   <= {{BW{1'b0}}, w_grant_data};
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            r_owner   <= w_grant_id;
          end
        end
        S_CONV: begin
          r_shreg   <= w_shifted;
          r_ovf_acc <= w_ovf_next;
          r_cnt     <= r_cnt + CW'(1);
          if (w_last_shift) begin
            r_bcd_out <= w_shifted[SW-1:IN_W];
            r_ovf     <= w_ovf_next;
            r_done_id <= r_owner;
          end
        end
        S_DONE: begin
          r_last_served <= r_owner;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb/tb_bcd_conv_sched.sv - scoreboard bench for bcd_conv_sched (32/10 and 16/4 instances)
module tb_bcd_conv_sched;

  typedef struct {
    bit          id;
    logic [39:0] bcd;
    bit          ovf;
  } exp_t;

  logic clk;
  logic rstn;

  logic        req0_a, req1_a;
  logic [31:0] data0_a, data1_a;
  logic        ack0_a, ack1_a, busy_a, done_a, done_id_a, ovf_a;
  logic [39:0] bcd_a;

  logic        req0_b, req1_b;
  logic [15:0] data0_b, data1_b;
  logic        ack0_b, ack1_b, busy_b, done_b, done_id_b, ovf_b;
  logic [15:0] bcd_b;

  int total = 0;
  int bad   = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  bit   ls;

  bcd_conv_sched #(.IN_W(32), .DIGITS(10)) u_dut_a (
    .clk(clk), .rstn(rstn),
    .req0(req0_a), .data0(data0_a), .req1(req1_a), .data1(data1_a),
    .ack0(ack0_a), .ack1(ack1_a), .busy(busy_a), .done(done_a),
    .done_id(done_id_a), .bcd_out(bcd_a), .ovf(ovf_a)
  );

  bcd_conv_sched #(.IN_W(16), .DIGITS(4)) u_dut_b (
    .clk(clk), .rstn(rstn),
    .req0(req0_b), .data0(data0_b), .req1(req1_b), .data1(data1_b),
    .ack0(ack0_b), .ack1(ack1_b), .busy(busy_b), .done(done_b),
    .done_id(done_id_b), .bcd_out(bcd_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Decimal digits by repeated division; anything left over did not fit.
  function automatic exp_t model(input bit id, input longint unsigned v, input int digits);
    exp_t e;
    e.id  = id;
    e.bcd = '0;
    for (int i = 0; i < digits; i++) begin
      e.bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    e.ovf = (v != 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rstn && (done_a || ack0_a || ack1_a)) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_done", 64'd1, 64'd0);
      end else begin
        ea = qa.pop_front();
        chk("a_done", done_a, 1);
        chk("a_ack0", ack0_a, (ea.id == 1'b0));
        chk("a_ack1", ack1_a, (ea.id == 1'b1));
        chk("a_done_id", done_id_a, ea.id);
        chk("a_bcd", bcd_a, ea.bcd);
        chk("a_ovf", ovf_a, ea.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && (done_b || ack0_b || ack1_b)) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_done", 64'd1, 64'd0);
      end else begin
        eb = qb.pop_front();
        chk("b_ack0", ack0_b, (eb.id == 1'b0));
        chk("b_done_id", done_id_b, eb.id);
        chk("b_bcd", bcd_b, eb.bcd[15:0]);
        chk("b_ovf", ovf_b, eb.ovf);
      end
    end
  end

  // Issues one request pattern on instance A from IDLE and follows it until
  // every raised request has been acked. Expected results are queued in the
  // order the round-robin rule serves them.
  task automatic round_a(input bit r0, input bit r1, input logic [31:0] d0,
                         input logic [31:0] d1, input bit scramble);
    int k;
    int t_first;
    int t_second;
    bit first_id;
    first_id = (r0 && r1) ? ~ls : r1;
    qa.push_back(model(first_id, first_id ? d1 : d0, 10));
    if (r0 && r1) begin
      qa.push_back(model(~first_id, first_id ? d0 : d1, 10));
      ls = ~first_id;
    end else begin
      ls = first_id;
    end
    req0_a = r0; data0_a = d0;
    req1_a = r1; data1_a = d1;
    @(negedge clk);
    k = 1;
    chk("a_busy_after_grant", busy_a, 1);
    t_first  = 0;
    t_second = 0;
    while ((req0_a || req1_a) && k < 300) begin
      if (scramble && k == 5) begin
        if (first_id == 1'b0) data0_a = $urandom;
        else                  data1_a = $urandom;
      end
      @(negedge clk);
      k++;
      if (done_a) begin
        if (t_first == 0) t_first = k;
        else              t_second = k;
      end
      if (ack0_a) req0_a = 1'b0;
      if (ack1_a) req1_a = 1'b0;
    end
    chk("a_timeout", {62'd0, req0_a, req1_a}, 0);
    chk("a_latency", t_first, 33);
    if (r0 && r1) chk("a_throughput", t_second - t_first, 34);
    @(negedge clk);
  endtask

  task automatic round_b(input logic [15:0] v);
    int k;
    qb.push_back(model(1'b0, v, 4));
    req0_b  = 1'b1;
    data0_b = v;
    k = 0;
    while (req0_b && k < 100) begin
      @(negedge clk);
      k++;
      if (ack0_b) req0_b = 1'b0;
    end
    chk("b_timeout", req0_b, 0);
    @(negedge clk);
  endtask

  initial begin
    int n_ack;
    bit r0;
    bit r1;
    rstn = 1'b0;
    req0_a = 0; req1_a = 0; data0_a = '0; data1_a = '0;
    req0_b = 0; req1_b = 0; data0_b = '0; data1_b = '0;
    ls = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_ack", {ack0_a, ack1_a}, 0);
    chk("rst_done_id", done_id_a, 0);
    chk("rst_bcd", bcd_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_b_bcd", bcd_b, 0);
    rstn = 1'b1;
    @(negedge clk);

    round_a(1, 0, 32'hFFFF_FFFF, 32'd0, 0);

    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    ls = 1'b1;
    @(negedge clk);
    round_a(1, 1, 32'd12345678, 32'd9, 0);

    round_a(1, 0, $urandom, 32'd0, 0);
    repeat (4) round_a(1, 1, $urandom, $urandom, 0);

    round_a(1, 0, 32'd0, 32'd0, 0);
    round_a(1, 0, $urandom, 32'd0, 1);
    round_a(0, 1, 32'd0, $urandom, 1);

    req0_a  = 1'b1;
    data0_a = $urandom;
    repeat (11) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_ack0", ack0_a, 0);
    chk("abort_bcd", bcd_a, 0);
    chk("abort_ovf", ovf_a, 0);
    req0_a = 1'b0;
    ls = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    n_ack = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_a || ack0_a || ack1_a) n_ack++;
    end
    chk("abort_no_ack", n_ack, 0);
    round_a(1, 0, $urandom, 32'd0, 0);

    round_b(16'd9999);
    round_b(16'd65535);
    round_b(16'd0);
    repeat (6) round_b(16'($urandom));

    repeat (20) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      round_a(r0, r1, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
